// File: rtl/trap_sequencer_if.sv
// Request/response bundle between control unit, CSR bank and trap sequencer.
// master = control/CSR side, slave = the sequencer.
interface trap_sequencer_if #(
  parameter int DATA_SIZE = 64
);
  logic                 illegal_instruction;
  logic                 ecall;
  logic                 mret;
  logic                 sret;
  logic                 interrupt_pending;
  logic [3:0]           interrupt_cause;
  logic [1:0]           privilege_mode;
  logic [DATA_SIZE-1:0] id_pc;
  logic                 mem_busy;
  logic [DATA_SIZE-1:0] trap_vector;
  logic [DATA_SIZE-1:0] xret_addr;

  logic                 stall_if;
  logic                 flush_id_ex;
  logic                 flush_all;
  logic                 csr_trap_wr;
  logic                 csr_xret;
  logic [DATA_SIZE-1:0] trap_epc;
  logic [DATA_SIZE-1:0] trap_cause;
  logic                 pc_redirect_en;
  logic [DATA_SIZE-1:0] pc_redirect_addr;
  logic                 drain_timeout;
  logic                 busy;

  modport master (
    output illegal_instruction, ecall, mret, sret,
    output interrupt_pending, interrupt_cause,
    output privilege_mode, id_pc, mem_busy,
    output trap_vector, xret_addr,
    input  stall_if, flush_id_ex, flush_all,
    input  csr_trap_wr, csr_xret,
    input  trap_epc, trap_cause,
    input  pc_redirect_en, pc_redirect_addr,
    input  drain_timeout, busy
  );

  modport slave (
    input  illegal_instruction, ecall, mret, sret,
    input  interrupt_pending, interrupt_cause,
    input  privilege_mode, id_pc, mem_busy,
    input  trap_vector, xret_addr,
    output stall_if, flush_id_ex, flush_all,
    output csr_trap_wr, csr_xret,
    output trap_epc, trap_cause,
    output pc_redirect_en, pc_redirect_addr,
    output drain_timeout, busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap / xRET sequencer: squash, drain, CSR commit, PC redirect.
// Stall/flush outputs are ORed with the hazard unit's.
module trap_sequencer #(
  parameter int DATA_SIZE     = 64,
  parameter int DRAIN_TIMEOUT = 16
) (
  input logic             clock,
  input logic             reset,
  trap_sequencer_if.slave bus
);
  localparam int CW = $clog2(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        cnt;
  logic                 is_xret;
  logic                 is_irq;
  logic [3:0]           irq_code;
  logic [DATA_SIZE-1:0] epc_q;
  logic [DATA_SIZE-1:0] cause_q;
  logic [DATA_SIZE-1:0] target_q;

  logic                 event_req;
  logic                 xret_req;
  logic [DATA_SIZE-1:0] cause_nx;
  logic [DATA_SIZE-1:0] base;
  logic [DATA_SIZE-1:0] target_nx;

  assign event_req = !reset && (bus.interrupt_pending
                   | bus.illegal_instruction | bus.ecall
                   | bus.mret | bus.sret);

  assign xret_req = !bus.interrupt_pending
                 && !bus.illegal_instruction
                 && !bus.ecall;

  always_comb begin
    if (bus.interrupt_pending)
      cause_nx = {1'b1, {(DATA_SIZE-5){1'b0}},
                  bus.interrupt_cause};
    else if (bus.illegal_instruction)
      cause_nx = DATA_SIZE'(2);
    else if (bus.ecall)
      cause_nx = DATA_SIZE'(8)
               + DATA_SIZE'(bus.privilege_mode);
    else
      cause_nx = cause_q;
  end

  // Vectoring applies to interrupts only; exceptions use the base.
  always_comb begin
    base = {bus.trap_vector[DATA_SIZE-1:2], 2'b00};
    if (is_xret)
      target_nx = bus.xret_addr;
    else if (is_irq && bus.trap_vector[1:0] == 2'b01)
      target_nx = base + DATA_SIZE'({irq_code, 2'b00});
    else
      target_nx = base;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx             = state;
    bus.stall_if         = 1'b0;
    bus.flush_id_ex      = 1'b0;
    bus.flush_all        = 1'b0;
    bus.csr_trap_wr      = 1'b0;
    bus.csr_xret         = 1'b0;
    bus.pc_redirect_en   = 1'b0;
    bus.pc_redirect_addr = '0;
    bus.drain_timeout    = 1'b0;
    bus.busy             = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (event_req) begin
          bus.stall_if    = 1'b1;
          bus.flush_id_ex = 1'b1;
          state_nx        = DRAIN;
        end
      end
      DRAIN: begin
        bus.stall_if = 1'b1;
        if (!bus.mem_busy) begin
          state_nx = COMMIT;
        end else if (cnt == CNT_LAST) begin
          bus.drain_timeout = 1'b1;
          state_nx          = COMMIT;
        end
      end
      COMMIT: begin
        bus.stall_if    = 1'b1;
        bus.flush_all   = 1'b1;
        bus.csr_trap_wr = !is_xret;
        bus.csr_xret    = is_xret;
        state_nx        = REDIRECT;
      end
      REDIRECT: begin
        bus.pc_redirect_en   = 1'b1;
        bus.pc_redirect_addr = target_q;
        bus.flush_all        = 1'b1;
        state_nx             = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      is_xret  <= 1'b0;
      is_irq   <= 1'b0;
      irq_code <= '0;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (event_req) begin
            cnt      <= '0;
            epc_q    <= bus.id_pc;
            cause_q  <= cause_nx;
            is_irq   <= bus.interrupt_pending;
            is_xret  <= xret_req;
            irq_code <= bus.interrupt_cause;
          end
        end
        DRAIN:    cnt <= cnt + 1'b1;
        COMMIT:   target_q <= target_nx;
        default:  ;
      endcase
    end
  end

  assign bus.trap_epc   = epc_q;
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer.
// One task per scenario, inline comparisons.
module tb_trap_sequencer;
  localparam int DS = 64;
  localparam int DT = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  trap_sequencer_if #(.DATA_SIZE(DS)) bus ();

  trap_sequencer #(
    .DATA_SIZE(DS),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_req();
    bus.illegal_instruction = 1'b0;
    bus.ecall               = 1'b0;
    bus.mret                = 1'b0;
    bus.sret                = 1'b0;
    bus.interrupt_pending   = 1'b0;
    bus.interrupt_cause     = 4'd0;
  endtask

  task automatic test_reset();
    clear_req();
    bus.privilege_mode = 2'd3;
    bus.id_pc          = '0;
    bus.mem_busy       = 1'b0;
    bus.trap_vector    = '0;
    bus.xret_addr      = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.stall_if !== 1'b0
        || bus.flush_all !== 1'b0 || bus.flush_id_ex !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: busy=%b stall=%b fall=%b fidex=%b want 0",
               bus.busy, bus.stall_if, bus.flush_all, bus.flush_id_ex);
    end
    n_chk++;
    if (bus.trap_epc !== '0 || bus.trap_cause !== '0
        || bus.pc_redirect_addr !== '0 || bus.pc_redirect_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: epc=%h cause=%h addr=%h en=%b want 0",
               bus.trap_epc, bus.trap_cause,
               bus.pc_redirect_addr, bus.pc_redirect_en);
    end
  endtask

  task automatic test_illegal();
    step();
    bus.privilege_mode      = 2'd3;
    bus.id_pc               = 64'h1000;
    bus.trap_vector         = 64'h8000_0001;
    bus.mem_busy            = 1'b0;
    bus.illegal_instruction = 1'b1;
    #1;
    n_chk++;
    if (bus.stall_if !== 1'b1 || bus.flush_id_ex !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_c0: stall=%b fidex=%b want 1 1",
               bus.stall_if, bus.flush_id_ex);
    end
    step();
    clear_req();
    #1;
    n_chk++;
    if (bus.busy !== 1'b1 || bus.stall_if !== 1'b1
        || bus.flush_all !== 1'b0 || bus.csr_trap_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_c1: busy=%b stall=%b fall=%b wr=%b want 1 1 0 0",
               bus.busy, bus.stall_if, bus.flush_all, bus.csr_trap_wr);
    end
    step();
    n_chk++;
    if (bus.csr_trap_wr !== 1'b1 || bus.csr_xret !== 1'b0
        || bus.flush_all !== 1'b1 || bus.stall_if !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_c2: wr=%b xret=%b fall=%b stall=%b want 1 0 1 1",
               bus.csr_trap_wr, bus.csr_xret, bus.flush_all, bus.stall_if);
    end
    n_chk++;
    if (bus.trap_cause !== 64'd2 || bus.trap_epc !== 64'h1000) begin
      n_fail++;
      $display("FAIL ill_latch: cause=%h epc=%h want 2 1000",
               bus.trap_cause, bus.trap_epc);
    end
    step();
    n_chk++;
    if (bus.pc_redirect_en !== 1'b1
        || bus.pc_redirect_addr !== 64'h8000_0000
        || bus.stall_if !== 1'b0 || bus.flush_all !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_c3: en=%b addr=%h stall=%b fall=%b want 1 80000000 0 1",
               bus.pc_redirect_en, bus.pc_redirect_addr,
               bus.stall_if, bus.flush_all);
    end
    step();
    n_chk++;
    if (bus.busy !== 1'b0 || bus.pc_redirect_addr !== '0
        || bus.pc_redirect_en !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_c4: busy=%b addr=%h en=%b want 0 0 0",
               bus.busy, bus.pc_redirect_addr, bus.pc_redirect_en);
    end
  endtask

  task automatic test_vectored_irq();
    bus.privilege_mode    = 2'd3;
    bus.id_pc             = 64'h2000;
    bus.trap_vector       = 64'h101;
    bus.interrupt_pending = 1'b1;
    bus.interrupt_cause   = 4'd7;
    bus.ecall             = 1'b1;
    #1;
    step();
    clear_req();
    step();
    n_chk++;
    if (bus.csr_trap_wr !== 1'b1
        || bus.trap_cause !== 64'h8000_0000_0000_0007
        || bus.trap_epc !== 64'h2000) begin
      n_fail++;
      $display("FAIL irq_commit: wr=%b cause=%h epc=%h want 1 8000000000000007 2000",
               bus.csr_trap_wr, bus.trap_cause, bus.trap_epc);
    end
    step();
    n_chk++;
    if (bus.pc_redirect_en !== 1'b1 || bus.pc_redirect_addr !== 64'h11C) begin
      n_fail++;
      $display("FAIL irq_redirect: en=%b addr=%h want 1 11c",
               bus.pc_redirect_en, bus.pc_redirect_addr);
    end
    step();
  endtask

  task automatic test_ecall();
    logic [1:0]  pm [3] = '{2'd0, 2'd1, 2'd3};
    logic [63:0] ce [3] = '{64'd8, 64'd9, 64'd11};
    for (int i = 0; i < 3; i++) begin
      bus.privilege_mode = pm[i];
      bus.trap_vector    = 64'h401;
      bus.id_pc          = 64'h3000 + 64'(i * 4);
      bus.ecall          = 1'b1;
      #1;
      step();
      clear_req();
      step();
      n_chk++;
      if (bus.csr_trap_wr !== 1'b1 || bus.trap_cause !== ce[i]) begin
        n_fail++;
        $display("FAIL ecall_cause[%0d]: wr=%b cause=%h want 1 %h",
                 i, bus.csr_trap_wr, bus.trap_cause, ce[i]);
      end
      step();
      n_chk++;
      if (bus.pc_redirect_en !== 1'b1 || bus.pc_redirect_addr !== 64'h400) begin
        n_fail++;
        $display("FAIL ecall_redirect[%0d]: en=%b addr=%h want 1 400",
                 i, bus.pc_redirect_en, bus.pc_redirect_addr);
      end
      step();
    end
  endtask

  task automatic test_drain_wait();
    bus.trap_vector         = 64'h500;
    bus.mem_busy            = 1'b1;
    bus.illegal_instruction = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      step();
      clear_req();
      if (c == 3) bus.mem_busy = 1'b0;
      #1;
      n_chk++;
      if (bus.stall_if !== 1'b1 || bus.csr_trap_wr !== 1'b0
          || bus.drain_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_c%0d: stall=%b wr=%b to=%b want 1 0 0",
                 c, bus.stall_if, bus.csr_trap_wr, bus.drain_timeout);
      end
    end
    step();
    n_chk++;
    if (bus.csr_trap_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_commit: wr=%b want 1", bus.csr_trap_wr);
    end
    step();
    n_chk++;
    if (bus.pc_redirect_en !== 1'b1 || bus.pc_redirect_addr !== 64'h500) begin
      n_fail++;
      $display("FAIL drain_redirect: en=%b addr=%h want 1 500",
               bus.pc_redirect_en, bus.pc_redirect_addr);
    end
    step();
  endtask

  task automatic test_timeout();
    bus.privilege_mode = 2'd3;
    bus.trap_vector    = 64'h600;
    bus.mem_busy       = 1'b1;
    bus.ecall          = 1'b1;
    #1;
    for (int c = 1; c < DT; c++) begin
      step();
      clear_req();
      #1;
      n_chk++;
      if (bus.drain_timeout !== 1'b0 || bus.csr_trap_wr !== 1'b0
          || bus.stall_if !== 1'b1) begin
        n_fail++;
        $display("FAIL to_wait_c%0d: to=%b wr=%b stall=%b want 0 0 1",
                 c, bus.drain_timeout, bus.csr_trap_wr, bus.stall_if);
      end
    end
    step();
    n_chk++;
    if (bus.drain_timeout !== 1'b1 || bus.stall_if !== 1'b1) begin
      n_fail++;
      $display("FAIL to_pulse: to=%b stall=%b want 1 1",
               bus.drain_timeout, bus.stall_if);
    end
    step();
    bus.mem_busy = 1'b0;
    #1;
    n_chk++;
    if (bus.csr_trap_wr !== 1'b1 || bus.drain_timeout !== 1'b0
        || bus.trap_cause !== 64'd11) begin
      n_fail++;
      $display("FAIL to_commit: wr=%b to=%b cause=%h want 1 0 b",
               bus.csr_trap_wr, bus.drain_timeout, bus.trap_cause);
    end
    step();
    n_chk++;
    if (bus.pc_redirect_en !== 1'b1 || bus.pc_redirect_addr !== 64'h600) begin
      n_fail++;
      $display("FAIL to_redirect: en=%b addr=%h want 1 600",
               bus.pc_redirect_en, bus.pc_redirect_addr);
    end
    step();
  endtask

  task automatic test_mret();
    bus.id_pc       = 64'h7000;
    bus.xret_addr   = 64'h2004;
    bus.trap_vector = 64'h900;
    bus.mret        = 1'b1;
    #1;
    step();
    clear_req();
    bus.illegal_instruction = 1'b1;
    step();
    n_chk++;
    if (bus.csr_xret !== 1'b1 || bus.csr_trap_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_commit: xret=%b wr=%b want 1 0",
               bus.csr_xret, bus.csr_trap_wr);
    end
    n_chk++;
    if (bus.trap_cause !== 64'd11 || bus.trap_epc !== 64'h7000) begin
      n_fail++;
      $display("FAIL mret_latch: cause=%h epc=%h want b 7000",
               bus.trap_cause, bus.trap_epc);
    end
    step();
    bus.illegal_instruction = 1'b0;
    #1;
    n_chk++;
    if (bus.pc_redirect_en !== 1'b1 || bus.pc_redirect_addr !== 64'h2004
        || bus.csr_trap_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_redirect: en=%b addr=%h wr=%b want 1 2004 0",
               bus.pc_redirect_en, bus.pc_redirect_addr, bus.csr_trap_wr);
    end
    step();
    n_chk++;
    if (bus.busy !== 1'b0 || bus.trap_cause !== 64'd11) begin
      n_fail++;
      $display("FAIL mret_idle: busy=%b cause=%h want 0 b",
               bus.busy, bus.trap_cause);
    end
  endtask

  task automatic test_back_to_back();
    bus.trap_vector         = 64'hA00;
    bus.id_pc               = 64'h4000;
    bus.illegal_instruction = 1'b1;
    #1;
    step();
    clear_req();
    step();
    step();
    step();
    bus.privilege_mode = 2'd1;
    bus.id_pc          = 64'h4004;
    bus.ecall          = 1'b1;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.stall_if !== 1'b1
        || bus.flush_id_ex !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b stall=%b fidex=%b want 0 1 1",
               bus.busy, bus.stall_if, bus.flush_id_ex);
    end
    step();
    clear_req();
    step();
    n_chk++;
    if (bus.csr_trap_wr !== 1'b1 || bus.trap_cause !== 64'd9
        || bus.trap_epc !== 64'h4004) begin
      n_fail++;
      $display("FAIL b2b_commit: wr=%b cause=%h epc=%h want 1 9 4004",
               bus.csr_trap_wr, bus.trap_cause, bus.trap_epc);
    end
    step();
    step();
  endtask

  task automatic test_reset_in_drain();
    bit pulsed = 1'b0;
    bus.id_pc               = 64'h5000;
    bus.mem_busy            = 1'b1;
    bus.illegal_instruction = 1'b1;
    #1;
    step();
    clear_req();
    reset = 1'b1;
    step();
    n_chk++;
    if (bus.busy !== 1'b0 || bus.stall_if !== 1'b0 || bus.flush_all !== 1'b0
        || bus.trap_epc !== '0 || bus.trap_cause !== '0
        || bus.drain_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drain: busy=%b stall=%b fall=%b epc=%h cause=%h to=%b want all 0",
               bus.busy, bus.stall_if, bus.flush_all,
               bus.trap_epc, bus.trap_cause, bus.drain_timeout);
    end
    reset = 1'b0;
    bus.mem_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.csr_trap_wr || bus.pc_redirect_en || bus.csr_xret)
        pulsed = 1'b1;
      step();
    end
    n_chk++;
    if (pulsed !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_pulse: pulsed=%b want 0", pulsed);
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_vectored_irq();
    test_ecall();
    test_drain_wait();
    test_timeout();
    test_mret();
    test_back_to_back();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
